// File: rtl/capture_ctrl_if.sv
// Capture controller bundle: run/ack control, sample strobe, trigger and
// trigger position in; sample RAM write port and capture status out.
// The master side is the command/sample source, the slave side is capture_ctrl.
interface capture_ctrl_if #(
    parameter int ADDR_W = 9
);
    // Control and sample inputs to the controller
    logic              run;
    logic              clr_done;
    logic              smpl_en;
    logic              trig;
    logic [ADDR_W-1:0] trig_pos;

    // Sample RAM write port and capture status
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;

    modport master (
        output run, clr_done, smpl_en, trig, trig_pos,
        input  we, waddr, armed, triggered, capture_done, trig_addr
    );

    modport slave (
        input  run, clr_done, smpl_en, trig, trig_pos,
        output we, waddr, armed, triggered, capture_done, trig_addr
    );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer for the analyzer sample RAM.
// Fills the circular RAM with pre-trigger history, arms, accepts the first
// trigger, writes trig_pos post-trigger samples and then freezes the RAM with
// capture_done raised until the readout path acknowledges it with clr_done.
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  bus
);

    // Fill target is DEPTH - trig_pos, so the fill counter carries one extra
    // bit to represent a full DEPTH-sample fill when trig_pos is zero.
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
    logic              armed_q, armed_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;

    logic              we;
    logic [ADDR_W-1:0] waddr_inc;
    logic [ADDR_W:0]   fill_cnt_inc;
    logic [ADDR_W:0]   fill_target;

    // A write happens on every sample strobe while the capture is live;
    // DONE and IDLE never write, which is what keeps a finished capture frozen.
    assign we           = bus.smpl_en & (state_q inside {S_FILL, S_ARMED, S_POST});
    assign waddr_inc    = waddr_q + ADDR_W'(1);
    assign fill_cnt_inc = fill_cnt_q + (ADDR_W + 1)'(1);
    assign fill_target  = DEPTH_W - {1'b0, bus.trig_pos};

    // State register and all capture bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
            fill_cnt_q  <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its peers regardless of statement order.
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            trig_addr_q <= trig_addr_d;
            post_cnt_q  <= post_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    // Next-state and register updates for the capture sequence
    always_comb begin
        // NOTE: every _d defaults to its held value first, so no path through
        // the case below can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        waddr_d     = waddr_q;
        trig_addr_d = trig_addr_q;
        post_cnt_d  = post_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        armed_d     = armed_q;
        triggered_d = triggered_q;
        done_d      = done_q;

        unique case (state_q)
            S_IDLE: begin
                // A new capture always starts writing from address 0.
                if (bus.run && !done_q) begin
                    state_d    = S_FILL;
                    waddr_d    = '0;
                    fill_cnt_d = '0;
                end
            end

            S_FILL: begin
                // Trigger is ignored until enough pre-trigger history exists.
                if (!bus.run) begin
                    state_d     = S_IDLE;
                    armed_d     = 1'b0;
                    triggered_d = 1'b0;
                end else if (we) begin
                    waddr_d    = waddr_inc;
                    fill_cnt_d = fill_cnt_inc;
                    if (fill_cnt_inc == fill_target) begin
                        state_d = S_ARMED;
                        armed_d = 1'b1;
                    end
                end
            end

            S_ARMED: begin
                if (!bus.run) begin
                    state_d     = S_IDLE;
                    armed_d     = 1'b0;
                    triggered_d = 1'b0;
                end else begin
                    // Keep overwriting the oldest history while waiting.
                    if (we) begin
                        waddr_d = waddr_inc;
                    end
                    if (bus.trig) begin
                        // A write in the trigger cycle is the last pre-trigger
                        // sample, so the first post-trigger slot is one past it.
                        triggered_d = 1'b1;
                        armed_d     = 1'b0;
                        trig_addr_d = we ? waddr_inc : waddr_q;
                        post_cnt_d  = bus.trig_pos;
                        if (bus.trig_pos == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
            end

            S_POST: begin
                if (!bus.run) begin
                    state_d     = S_IDLE;
                    armed_d     = 1'b0;
                    triggered_d = 1'b0;
                end else if (we) begin
                    // The last post-trigger write leaves waddr on the oldest
                    // sample, which is where readout begins.
                    waddr_d    = waddr_inc;
                    post_cnt_d = post_cnt_q - ADDR_W'(1);
                    if (post_cnt_q == ADDR_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                // RAM is frozen; only the readout acknowledge releases it.
                if (bus.clr_done) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b0;
                    triggered_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.we           = we;
    assign bus.waddr        = waddr_q;
    assign bus.trig_addr    = trig_addr_q;
    assign bus.armed        = armed_q;
    assign bus.triggered    = triggered_q;
    assign bus.capture_done = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a 16-entry RAM (ADDR_W = 4).
// Inputs change on the falling edge; outputs are compared on the falling edge
// after the rising edge that acted on them.
module tb_capture_ctrl;

    localparam int ADDR_W = 4;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    capture_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobe/trigger, inputs cleared afterwards.
    task automatic cyc(input logic en, input logic tg);
        bus.smpl_en = en;
        bus.trig    = tg;
        @(negedge clk);
        bus.smpl_en = 1'b0;
        bus.trig    = 1'b0;
    endtask

    // n decimated samples: strobe every second cycle.
    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        bus.clr_done = 1'b1;
        @(negedge clk);
        bus.clr_done = 1'b0;
    endtask

    // Watchdog: the directed sequence is a few thousand ns long.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.clr_done = 1'b0;
        bus.smpl_en  = 1'b0;
        bus.trig     = 1'b0;
        bus.trig_pos = 4'd4;
        #3;
        check("rst_waddr",     32'(bus.waddr), 0);
        check("rst_trig_addr", 32'(bus.trig_addr), 0);
        check("rst_flags",     32'({bus.armed, bus.triggered, bus.capture_done, bus.we}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: trig between samples after armed, trig_pos = 4
        bus.run = 1'b1;
        cyc(1'b0, 1'b0);
        bus.smpl_en = 1'b1;
        #1 check("t1_we_fill", 32'(bus.we), 1);
        @(negedge clk);
        bus.smpl_en = 1'b0;
        @(negedge clk);
        sample(10);
        check("t1_armed_11", 32'(bus.armed), 0);
        check("t1_waddr_11", 32'(bus.waddr), 11);
        sample(1);
        check("t1_armed_12", 32'(bus.armed), 1);
        check("t1_waddr_12", 32'(bus.waddr), 12);
        cyc(1'b0, 1'b1);
        check("t1_triggered", 32'(bus.triggered), 1);
        check("t1_armed_off", 32'(bus.armed), 0);
        check("t1_trig_addr", 32'(bus.trig_addr), 12);
        sample(3);
        check("t1_done_early", 32'(bus.capture_done), 0);
        check("t1_waddr_15",   32'(bus.waddr), 15);
        sample(1);
        check("t1_done",       32'(bus.capture_done), 1);
        check("t1_waddr_end",  32'(bus.waddr), 0);
        bus.smpl_en = 1'b1;
        #1 check("t1_we_done", 32'(bus.we), 0);
        bus.smpl_en = 1'b0;
        sample(2);
        check("t1_done_held",  32'(bus.capture_done), 1);
        check("t1_waddr_held", 32'(bus.waddr), 0);
        pulse_clr();
        check("t1_clr_done", 32'({bus.capture_done, bus.triggered}), 0);

        // 2: trig 20 samples after armed, waddr wraps
        cyc(1'b0, 1'b0);
        check("t2_restart_waddr", 32'(bus.waddr), 0);
        sample(12);
        check("t2_armed", 32'(bus.armed), 1);
        sample(20);
        check("t2_waddr_wrap", 32'(bus.waddr), 0);
        check("t2_still_armed", 32'({bus.armed, bus.triggered}), 32'b10);
        cyc(1'b0, 1'b1);
        check("t2_trig_addr", 32'(bus.trig_addr), 0);
        sample(4);
        check("t2_done",      32'(bus.capture_done), 1);
        check("t2_waddr_end", 32'(bus.waddr), 4);
        pulse_clr();

        // 3: trig during FILL is ignored
        cyc(1'b0, 1'b0);
        sample(5);
        cyc(1'b0, 1'b1);
        check("t3_fill_trig", 32'({bus.armed, bus.triggered}), 0);
        sample(6);
        check("t3_armed_11", 32'(bus.armed), 0);
        sample(1);
        check("t3_armed_12", 32'(bus.armed), 1);
        cyc(1'b0, 1'b1);
        check("t3_triggered", 32'(bus.triggered), 1);
        check("t3_trig_addr", 32'(bus.trig_addr), 12);

        // 6: run dropped mid-POST aborts; clr_done in IDLE ignored; restart at 0
        sample(2);
        check("t6_waddr_post", 32'(bus.waddr), 14);
        bus.run = 1'b0;
        cyc(1'b0, 1'b0);
        check("t6_abort_flags", 32'({bus.armed, bus.triggered, bus.capture_done}), 0);
        bus.smpl_en = 1'b1;
        #1 check("t6_we_idle", 32'(bus.we), 0);
        bus.smpl_en = 1'b0;
        @(negedge clk);
        pulse_clr();
        check("t6_clr_idle", 32'({bus.capture_done, bus.triggered}), 0);
        bus.run = 1'b1;
        cyc(1'b0, 1'b0);
        check("t6_restart_waddr", 32'(bus.waddr), 0);
        sample(1);
        check("t6_waddr_1", 32'(bus.waddr), 1);

        // 4: trig_pos = 0 -> full fill, done on trigger edge
        bus.run = 1'b0;
        cyc(1'b0, 1'b0);
        bus.trig_pos = 4'd0;
        bus.run = 1'b1;
        cyc(1'b0, 1'b0);
        sample(15);
        check("t4_armed_15", 32'(bus.armed), 0);
        sample(1);
        check("t4_armed_16", 32'(bus.armed), 1);
        check("t4_waddr_16", 32'(bus.waddr), 0);
        cyc(1'b0, 1'b1);
        check("t4_done",      32'(bus.capture_done), 1);
        check("t4_triggered", 32'(bus.triggered), 1);
        check("t4_trig_addr", 32'(bus.trig_addr), 0);
        for (int i = 0; i < 3; i++) begin
            bus.smpl_en = 1'b1;
            #1 check("t4_no_we", 32'(bus.we), 0);
            @(negedge clk);
            bus.smpl_en = 1'b0;
        end
        check("t4_waddr_frozen", 32'(bus.waddr), 0);

        // 5: trig coincident with a write at waddr 12
        bus.run = 1'b0;
        pulse_clr();
        bus.trig_pos = 4'd4;
        bus.run = 1'b1;
        cyc(1'b0, 1'b0);
        sample(12);
        check("t5_armed", 32'(bus.armed), 1);
        cyc(1'b1, 1'b1);
        check("t5_trig_addr", 32'(bus.trig_addr), 13);
        check("t5_waddr_13",  32'(bus.waddr), 13);
        cyc(1'b0, 1'b0);
        sample(3);
        check("t5_done_early", 32'(bus.capture_done), 0);
        sample(1);
        check("t5_done",      32'(bus.capture_done), 1);
        check("t5_waddr_end", 32'(bus.waddr), 1);

        // Async reset mid-ARMED clears everything without a clock edge
        pulse_clr();
        cyc(1'b0, 1'b0);
        sample(12);
        check("rst2_armed_before", 32'(bus.armed), 1);
        #2;
        rst_n       = 1'b0;
        bus.smpl_en = 1'b1;
        #1;
        check("rst2_waddr", 32'(bus.waddr), 0);
        check("rst2_flags", 32'({bus.armed, bus.triggered, bus.capture_done, bus.we}), 0);
        check("rst2_trig_addr", 32'(bus.trig_addr), 0);
        bus.smpl_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
